// File: rtl/xlr8_dm_dma.sv
// Block copy/fill engine on the single-port AVR data memory. It issues accesses
// only in cycles where the external arbiter grants it the DM port.
module xlr8_dm_dma #(
    parameter int dm_size = 1
) (
    input  logic        cp2,
    input  logic        rst,
    input  logic        start,
    input  logic        mode,
    input  logic [15:0] src_addr,
    input  logic [15:0] dst_addr,
    input  logic [15:0] length,
    input  logic [7:0]  fill_data,
    input  logic        abort,
    output logic        busy,
    output logic        done,
    output logic [15:0] remaining,
    input  logic        dm_gnt,
    output logic        dm_ce,
    output logic [15:0] dm_addr,
    output logic [7:0]  dm_din,
    output logic        dm_we,
    input  logic [7:0]  dm_dout
);

    // The RAM decodes only the low 10+clog2(dm_size) address bits; pointers stay 16 bits.
    if (dm_size < 1 || dm_size > 64) begin : g_bad_dm_size
        $error("xlr8_dm_dma: dm_size must be 1..64");
    end

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RD,
        ST_CAP,
        ST_WR,
        ST_DONE
    } state_t;

    state_t      state_q, state_d;
    logic        mode_q, mode_d;
    logic [15:0] src_ptr_q, src_ptr_d;
    logic [15:0] dst_ptr_q, dst_ptr_d;
    logic [15:0] remaining_q, remaining_d;
    logic [7:0]  fill_q, fill_d;
    logic [7:0]  data_q, data_d;
    logic [15:0] addr_q, addr_d;
    logic [7:0]  din_q, din_d;

    always_comb begin
        // NOTE: every signal gets a default before the case so no path infers a latch.
        state_d     = state_q;
        mode_d      = mode_q;
        src_ptr_d   = src_ptr_q;
        dst_ptr_d   = dst_ptr_q;
        remaining_d = remaining_q;
        fill_d      = fill_q;
        data_d      = data_q;
        done        = 1'b0;
        dm_ce       = 1'b0;
        dm_we       = 1'b0;
        dm_addr     = addr_q;
        dm_din      = din_q;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    remaining_d = length;
                    if (length == 16'd0) begin
                        state_d = ST_DONE;
                    end else begin
                        mode_d    = mode;
                        src_ptr_d = src_addr;
                        dst_ptr_d = dst_addr;
                        fill_d    = fill_data;
                        state_d   = mode ? ST_WR : ST_RD;
                    end
                end
            end
            ST_RD: begin
                dm_addr = src_ptr_q;
                if (abort) begin
                    state_d = ST_DONE;
                end else begin
                    dm_ce = dm_gnt;
                    if (dm_gnt) begin
                        src_ptr_d = src_ptr_q + 16'd1;
                        state_d   = ST_CAP;
                    end
                end
            end
            ST_CAP: begin
                // The RAM already registered our read address, so the grant is irrelevant here.
                if (abort) begin
                    state_d = ST_DONE;
                end else begin
                    data_d  = dm_dout;
                    state_d = ST_WR;
                end
            end
            ST_WR: begin
                dm_addr = dst_ptr_q;
                dm_din  = mode_q ? fill_q : data_q;
                if (abort) begin
                    state_d = ST_DONE;
                end else begin
                    dm_ce = dm_gnt;
                    dm_we = dm_gnt;
                    if (dm_gnt) begin
                        dst_ptr_d   = dst_ptr_q + 16'd1;
                        remaining_d = remaining_q - 16'd1;
                        if (remaining_q == 16'd1) begin
                            state_d = ST_DONE;
                        end else begin
                            state_d = mode_q ? ST_WR : ST_RD;
                        end
                    end
                end
            end
            ST_DONE: begin
                done    = 1'b1;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase

        // Idle/capture/done cycles re-present the last address and data.
        addr_d = dm_addr;
        din_d  = dm_din;
    end

    // NOTE: state registers use non-blocking assignments so all flops update together.
    always_ff @(posedge cp2 or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            mode_q      <= 1'b0;
            src_ptr_q   <= 16'd0;
            dst_ptr_q   <= 16'd0;
            remaining_q <= 16'd0;
            fill_q      <= 8'd0;
            data_q      <= 8'd0;
            addr_q      <= 16'd0;
            din_q       <= 8'd0;
        end else begin
            state_q     <= state_d;
            mode_q      <= mode_d;
            src_ptr_q   <= src_ptr_d;
            dst_ptr_q   <= dst_ptr_d;
            remaining_q <= remaining_d;
            fill_q      <= fill_d;
            data_q      <= data_d;
            addr_q      <= addr_d;
            din_q       <= din_d;
        end
    end

    assign busy      = (state_q != ST_IDLE);
    assign remaining = remaining_q;

endmodule

// File: tb/tb_xlr8_dm_dma.sv
// Self-checking bench for xlr8_dm_dma: a behavioural DM RAM, a write scoreboard
// fed from a reference memory image, a vector table and a few hand-run corner cases.
module tb_xlr8_dm_dma;

    typedef struct {
        logic        mode;
        logic [15:0] src;
        logic [15:0] dst;
        logic [15:0] len;
        logic [7:0]  fill;
        logic        toggle;
        int          exp_lat;
    } vec_t;

    typedef struct {
        logic [15:0] addr;
        logic [7:0]  data;
    } wr_t;

    logic        cp2;
    logic        rst;
    logic        start;
    logic        mode;
    logic [15:0] src_addr;
    logic [15:0] dst_addr;
    logic [15:0] length;
    logic [7:0]  fill_data;
    logic        abort;
    logic        busy;
    logic        done;
    logic [15:0] remaining;
    logic        dm_gnt;
    logic        dm_ce;
    logic [15:0] dm_addr;
    logic [7:0]  dm_din;
    logic        dm_we;
    logic [7:0]  dm_dout;

    logic [7:0]  mem     [0:65535];
    logic [7:0]  exp_mem [0:65535];
    wr_t         sb[$];
    vec_t        vecs[7];
    int          tests;
    int          fails;
    int          ce_cnt;
    logic        gnt_toggle;
    logic        prev_rd;

    xlr8_dm_dma #(.dm_size(1)) dut (
        .cp2(cp2), .rst(rst), .start(start), .mode(mode),
        .src_addr(src_addr), .dst_addr(dst_addr), .length(length),
        .fill_data(fill_data), .abort(abort), .busy(busy), .done(done),
        .remaining(remaining), .dm_gnt(dm_gnt), .dm_ce(dm_ce),
        .dm_addr(dm_addr), .dm_din(dm_din), .dm_we(dm_we), .dm_dout(dm_dout)
    );

    initial cp2 = 1'b0;
    always #5 cp2 = ~cp2;

    function automatic logic [7:0] init_byte(input int i);
        logic [7:0] b;
        b = i[7:0] ^ 8'h3C;
        if (i == 32'h100) b = 8'h11;
        if (i == 32'h101) b = 8'h22;
        if (i == 32'h102) b = 8'h33;
        if (i == 32'h103) b = 8'h44;
        return b;
    endfunction

    // Synchronous single-port RAM: read data appears the cycle after the read edge.
    initial begin
        dm_dout = 8'h00;
        for (int i = 0; i < 65536; i++) mem[i] = init_byte(i);
        forever begin
            @(posedge cp2);
            if (dm_ce) begin
                dm_dout <= mem[dm_addr];
                if (dm_we) mem[dm_addr] <= dm_din;
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Bus monitor: grant discipline, capture cycle silence, and scoreboard pops.
    initial begin
        ce_cnt  = 0;
        prev_rd = 1'b0;
        forever begin
            @(negedge cp2);
            if (dm_ce) begin
                ce_cnt++;
                check("ce_needs_gnt", {31'd0, dm_gnt}, 32'd1);
            end
            if (prev_rd) check("cap_no_access", {31'd0, dm_ce}, 32'd0);
            prev_rd = dm_ce && !dm_we;
            if (dm_ce && dm_we) begin
                check("write_expected", {31'd0, (sb.size() != 0)}, 32'd1);
                if (sb.size() != 0) begin
                    wr_t w;
                    w = sb.pop_front();
                    check("wr_addr", {16'd0, dm_addr}, {16'd0, w.addr});
                    check("wr_data", {24'd0, dm_din}, {24'd0, w.data});
                end
            end
        end
    end

    task automatic tick();
        @(posedge cp2);
        #1;
        if (gnt_toggle) dm_gnt = ~dm_gnt;
    endtask

    task automatic push_expect(input vec_t v);
        for (int i = 0; i < int'(v.len); i++) begin
            wr_t         w;
            logic [15:0] sa;
            sa     = v.src + 16'(i);
            w.addr = v.dst + 16'(i);
            w.data = v.mode ? v.fill : exp_mem[sa];
            exp_mem[w.addr] = w.data;
            sb.push_back(w);
        end
    endtask

    task automatic drive_start(input vec_t v);
        start     = 1'b1;
        mode      = v.mode;
        src_addr  = v.src;
        dst_addr  = v.dst;
        length    = v.len;
        fill_data = v.fill;
    endtask

    task automatic run_vec(input vec_t v);
        int          n;
        int          ce0;
        logic [15:0] a;
        gnt_toggle = v.toggle;
        dm_gnt     = 1'b1;
        push_expect(v);
        ce0 = ce_cnt;
        drive_start(v);
        tick();
        start = 1'b0;
        n = 1;
        if (v.len != 16'd0) check("busy_in_xfer", {31'd0, busy}, 32'd1);
        while (!done && n < 400) begin
            tick();
            n++;
        end
        check("done_seen", {31'd0, done}, 32'd1);
        if (v.exp_lat != 0) check("latency", n, v.exp_lat);
        check("remaining_end", {16'd0, remaining}, 32'd0);
        tick();
        check("done_one_cycle", {31'd0, done}, 32'd0);
        check("busy_after", {31'd0, busy}, 32'd0);
        if (v.len == 16'd0) check("zero_len_no_ce", ce_cnt - ce0, 32'd0);
        check("sb_drained", sb.size(), 32'd0);
        for (int i = 0; i <= int'(v.len); i++) begin
            a = v.dst + 16'(i);
            check("mem_content", {24'd0, mem[a]}, {24'd0, exp_mem[a]});
        end
        gnt_toggle = 1'b0;
        dm_gnt     = 1'b1;
    endtask

    initial begin
        vec_t v;
        int   n;
        tests = 0;
        fails = 0;
        for (int i = 0; i < 65536; i++) exp_mem[i] = init_byte(i);
        vecs[0] = '{mode: 1'b0, src: 16'h0100, dst: 16'h0200, len: 16'd4, fill: 8'h00, toggle: 1'b0, exp_lat: 13};
        vecs[1] = '{mode: 1'b1, src: 16'h0000, dst: 16'h0010, len: 16'd3, fill: 8'hA5, toggle: 1'b0, exp_lat: 4};
        vecs[2] = '{mode: 1'b0, src: 16'h0300, dst: 16'h0340, len: 16'd2, fill: 8'h00, toggle: 1'b1, exp_lat: 0};
        vecs[3] = '{mode: 1'b0, src: 16'h0000, dst: 16'h0900, len: 16'd0, fill: 8'h00, toggle: 1'b0, exp_lat: 1};
        vecs[4] = '{mode: 1'b1, src: 16'h0000, dst: 16'hFFFF, len: 16'd2, fill: 8'h5A, toggle: 1'b0, exp_lat: 3};
        vecs[5] = '{mode: 1'b0, src: 16'h0400, dst: 16'h0401, len: 16'd3, fill: 8'h00, toggle: 1'b0, exp_lat: 10};
        vecs[6] = '{mode: 1'b1, src: 16'h0000, dst: 16'h0A00, len: 16'd1, fill: 8'hE7, toggle: 1'b0, exp_lat: 2};

        rst = 1'b1; start = 1'b0; mode = 1'b0; src_addr = 16'd0; dst_addr = 16'd0;
        length = 16'd0; fill_data = 8'd0; abort = 1'b0; dm_gnt = 1'b1; gnt_toggle = 1'b0;
        tick();
        tick();
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_done", {31'd0, done}, 32'd0);
        check("rst_remaining", {16'd0, remaining}, 32'd0);
        check("rst_ce", {31'd0, dm_ce}, 32'd0);
        check("rst_we", {31'd0, dm_we}, 32'd0);
        check("rst_addr", {16'd0, dm_addr}, 32'd0);
        check("rst_din", {24'd0, dm_din}, 32'd0);
        rst = 1'b0;
        tick();

        for (int k = 0; k < 7; k++) run_vec(vecs[k]);

        // A second start while busy must not disturb the running fill.
        v = '{mode: 1'b1, src: 16'h0000, dst: 16'h0500, len: 16'd3, fill: 8'h77, toggle: 1'b0, exp_lat: 4};
        push_expect(v);
        drive_start(v);
        tick();
        n = 1;
        start = 1'b1; mode = 1'b0; dst_addr = 16'h0600; length = 16'd1;
        tick();
        n++;
        start = 1'b0;
        while (!done && n < 400) begin
            tick();
            n++;
        end
        check("busy_start_latency", n, 32'd4);
        tick();
        check("busy_start_sb", sb.size(), 32'd0);
        check("busy_start_0x600", {24'd0, mem[16'h0600]}, {24'd0, exp_mem[16'h0600]});
        check("busy_start_0x502", {24'd0, mem[16'h0502]}, 32'h77);

        // Abort during the second write of a five-byte fill.
        v = '{mode: 1'b1, src: 16'h0000, dst: 16'h0700, len: 16'd1, fill: 8'hC3, toggle: 1'b0, exp_lat: 0};
        push_expect(v);
        v.len = 16'd5;
        drive_start(v);
        tick();
        start = 1'b0;
        tick();
        abort = 1'b1;
        #1;
        check("abort_we", {31'd0, dm_we}, 32'd0);
        check("abort_ce", {31'd0, dm_ce}, 32'd0);
        tick();
        abort = 1'b0;
        check("abort_done", {31'd0, done}, 32'd1);
        check("abort_remaining", {16'd0, remaining}, 32'd4);
        tick();
        check("abort_done_clear", {31'd0, done}, 32'd0);
        check("abort_sb", sb.size(), 32'd0);
        check("abort_0x700", {24'd0, mem[16'h0700]}, 32'hC3);
        check("abort_0x701", {24'd0, mem[16'h0701]}, {24'd0, exp_mem[16'h0701]});

        // Asynchronous reset in the middle of a copy.
        v = '{mode: 1'b0, src: 16'h0100, dst: 16'h0800, len: 16'd4, fill: 8'h00, toggle: 1'b0, exp_lat: 0};
        push_expect(v);
        drive_start(v);
        tick();
        start = 1'b0;
        for (int i = 0; i < 5; i++) tick();
        #2;
        rst = 1'b1;
        #1;
        check("mid_rst_busy", {31'd0, busy}, 32'd0);
        check("mid_rst_remaining", {16'd0, remaining}, 32'd0);
        check("mid_rst_ce", {31'd0, dm_ce}, 32'd0);
        check("mid_rst_we", {31'd0, dm_we}, 32'd0);
        check("mid_rst_addr", {16'd0, dm_addr}, 32'd0);
        check("mid_rst_din", {24'd0, dm_din}, 32'd0);
        tick();
        check("mid_rst_no_done", {31'd0, done}, 32'd0);
        rst = 1'b0;
        tick();
        check("post_rst_no_done", {31'd0, done}, 32'd0);
        sb.delete();
        for (int i = 0; i < 4; i++) exp_mem[16'h0800 + 16'(i)] = mem[16'h0800 + 16'(i)];

        v = '{mode: 1'b0, src: 16'h0100, dst: 16'h0B00, len: 16'd4, fill: 8'h00, toggle: 1'b0, exp_lat: 13};
        run_vec(v);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/xlr8_dm_dma.md
Name: xlr8_dm_dma

Overview:
- Bus-initiator engine for the single-port AVR data memory; the other end of the DM port.
- Drives ce/address/din/we toward the DM RAM and reads its q output.
- Performs block copy (DM to DM) or block fill (constant to DM), started by a host register block.
- Shares the DM port with the CPU through an external mux; the engine accesses the RAM only in cycles where dm_gnt is high.

Parameters:
- dm_size, 1, DM size in KB (1..64); sets active address width AW = 10 + ceil(log2(dm_size)).

Ports:
- cp2  input  1  system clock; all state updates on rising edge.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  one-cycle request; sampled only in IDLE.
- mode  input  1  0 = copy, 1 = fill; latched on accepted start.
- src_addr  input  16  copy source base; latched on start.
- dst_addr  input  16  destination base; latched on start.
- length  input  16  byte count; 0 = no transfer.
- fill_data  input  8  fill byte; latched on start.
- abort  input  1  stop the transfer early.
- busy  output  1  high in every state except IDLE.
- done  output  1  one-cycle pulse on completion or abort.
- remaining  output  16  bytes not yet written.
- dm_gnt  input  1  DM port granted to the engine this cycle.
- dm_ce  output  1  DM clock enable.
- dm_addr  output  16  DM address; the RAM uses the low AW bits.
- dm_din  output  8  DM write data.
- dm_we  output  1  DM write enable.
- dm_dout  input  8  DM read data; valid in the cycle after a read edge.

Behaviour:
- Reset values: state IDLE; busy 0, done 0, remaining 0, dm_ce 0, dm_we 0, dm_addr 0, dm_din 0; internal pointers and data register 0.
- Reset mid-transfer: abandons the transfer immediately; no done pulse.
- States: IDLE, RD, CAP, WR, DONE.

State transitions:
- IDLE, start=1, length=0: go to DONE; no DM access.
- IDLE, start=1, length≠0: latch all config; remaining=length; go to RD (copy) or WR (fill).
- start in any other state: ignored.
- RD: dm_addr=src_ptr, dm_ce=dm_gnt, dm_we=0. If dm_gnt: src_ptr+1 and go to CAP; else hold.
- CAP: no DM access (dm_ce=0). Latch dm_dout into data_q at the edge; go to WR. dm_gnt is ignored in CAP because the RAM address register already holds our read.
- WR: dm_addr=dst_ptr, dm_din = fill_data (fill) or data_q (copy), dm_we=dm_ce=dm_gnt. If dm_gnt: dst_ptr+1 and remaining−1; if remaining was 1 go to DONE, else go to RD (copy) or stay in WR (fill). Else hold.
- DONE: done=1 for exactly one cycle; go to IDLE.
- abort in RD/CAP/WR: force dm_ce=dm_we=0 in that same cycle; go to DONE; remaining holds the unwritten count.
- abort in IDLE or DONE: ignored.
- dm_addr/dm_din/dm_ce/dm_we are combinational from state/registers/dm_gnt. In IDLE/CAP/DONE, dm_ce=dm_we=0 and dm_addr/dm_din hold their last values.

Arithmetic and timing:
- Pointers are 16 bits and wrap 0xFFFF→0x0000; the RAM aliases above its AW bits; no range check.
- Overlapping src/dst is copied forward byte by byte, with no hazard correction.
- Throughput with dm_gnt held high: copy = 3 cycles/byte, fill = 1 cycle/byte, plus 1 DONE cycle.
- Start-to-done latency with dm_gnt held high: copy = 3N+1 edges, fill = N+1 edges.

Test Plan:
- Copy: DM[0x100..0x103]=11,22,33,44; start copy src=0x100 dst=0x200 len=4, dm_gnt=1 -> DM[0x200..0x203]=11,22,33,44; done pulse 13 cycles after the start edge; busy=1 during transfer; remaining ends at 0.
- Fill: start fill dst=0x010 len=3 fill=0xA5 -> dm_we high 3 consecutive cycles at addresses 0x010, 0x011, 0x012; done on the 4th cycle; DM[0x013] unchanged.
- Grant stall: copy len=2 with dm_gnt toggled 0/1 every cycle -> no dm_ce while dm_gnt=0; data correct; CAP never stalls.
- Zero length and ignored start: start len=0 -> done pulse next cycle, no dm_ce ever. A start while busy -> no effect.
- Abort: abort during the second WR of a len=5 fill -> dm_we=0 that cycle; done next cycle; remaining=4; only 1 byte written.
- Wrap and reset: fill dst=0xFFFF len=2 -> writes at 0xFFFF then 0x0000. Assert rst mid-copy -> all outputs 0 asynchronously; no done pulse; next start works normally.
